// File: rtl/calc_sequencer.sv
// Per-sample sequencer for the MSDAP filter datapath: walks the rj segments, issues
// coefficient / sample reads, steers the ALU and shifter, and flags y(n) complete.
module calc_sequencer #(
  parameter int NUM_SEG = 16,
  parameter int COEF_AW = 9,
  parameter int DATA_AW = 8,
  parameter int RJ_W    = 8,
  localparam int SEG_AW = $clog2(NUM_SEG)
) (
  input  logic               Sclk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [DATA_AW-1:0] sample_ptr,
  input  logic               clear_hist,
  output logic [SEG_AW-1:0]  rj_addr,
  input  logic [RJ_W-1:0]    rj_data,
  output logic [COEF_AW-1:0] coef_addr,
  input  logic [DATA_AW:0]   coef_data,
  output logic [DATA_AW-1:0] data_addr,
  output logic               acc_clr,
  output logic               alu_en,
  output logic               alu_sub,
  output logic               alu_zero,
  output logic [2:0]         calc_stage,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic [2:0]         state_dbg
);

  // Handshake: start is a single-cycle pulse accepted only in IDLE; busy covers the
  // whole calculation and done is the one-cycle completion strobe (no backpressure).

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_RJ = 3'd1,
    S_RJ_WAIT = 3'd2,
    S_ACCUM   = 3'd3,
    S_DRAIN1  = 3'd4,
    S_DRAIN2  = 3'd5,
    S_SHIFT   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [SEG_AW-1:0]  LAST_SEG = SEG_AW'(NUM_SEG - 1);
  localparam logic [SEG_AW-1:0]  SEG_ONE  = SEG_AW'(1);
  localparam logic [COEF_AW-1:0] COEF_ONE = COEF_AW'(1);
  localparam logic [RJ_W-1:0]    RJ_ONE   = RJ_W'(1);
  localparam logic [DATA_AW:0]   N_ONE    = (DATA_AW + 1)'(1);
  localparam logic [DATA_AW:0]   N_MAX    = (DATA_AW + 1)'(2 ** DATA_AW);

  state_t               state, state_n;
  logic [SEG_AW-1:0]    j;
  logic [COEF_AW-1:0]   coef_ptr;
  logic [DATA_AW:0]     n_count;
  logic [RJ_W-1:0]      cnt;
  logic [DATA_AW-1:0]   ptr;
  logic                 v1;
  logic [DATA_AW-1:0]   k;

  assign k = coef_data[DATA_AW-1:0];

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (start) state_n = S_LOAD_RJ;
      S_LOAD_RJ: state_n = S_RJ_WAIT;
      S_RJ_WAIT: state_n = (rj_data != '0) ? S_ACCUM : S_DRAIN1;
      S_ACCUM:   if (cnt == RJ_ONE) state_n = S_DRAIN1;
      S_DRAIN1:  state_n = S_DRAIN2;
      S_DRAIN2:  state_n = S_SHIFT;
      S_SHIFT:   state_n = (j == LAST_SEG) ? S_DONE : S_LOAD_RJ;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (clear_hist) state_n = S_IDLE;
  end

  // Datapath registers; v1 marks a coefficient word arriving from the ROM this cycle.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      j        <= '0;
      coef_ptr <= '0;
      n_count  <= '0;
      cnt      <= '0;
      ptr      <= '0;
      v1       <= 1'b0;
      alu_en   <= 1'b0;
      alu_sub  <= 1'b0;
      alu_zero <= 1'b0;
      acc_clr  <= 1'b0;
      overrun  <= 1'b0;
    end else if (clear_hist) begin
      j        <= '0;
      coef_ptr <= '0;
      n_count  <= '0;
      cnt      <= '0;
      v1       <= 1'b0;
      alu_en   <= 1'b0;
      alu_sub  <= 1'b0;
      alu_zero <= 1'b0;
      acc_clr  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      acc_clr  <= 1'b0;
      overrun  <= start && (state != S_IDLE);
      v1       <= (state == S_ACCUM);
      alu_en   <= v1;
      alu_sub  <= v1 && coef_data[DATA_AW];
      alu_zero <= v1 && ({1'b0, k} >= n_count);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ptr      <= sample_ptr;
            n_count  <= (n_count == N_MAX) ? n_count : n_count + N_ONE;
            j        <= '0;
            coef_ptr <= '0;
            acc_clr  <= 1'b1;
          end
        end
        S_RJ_WAIT: cnt <= rj_data;
        S_ACCUM: begin
          coef_ptr <= coef_ptr + COEF_ONE;
          cnt      <= cnt - RJ_ONE;
        end
        S_SHIFT: j <= j + SEG_ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    rj_addr    = (state == S_LOAD_RJ) ? j : '0;
    coef_addr  = (state == S_ACCUM) ? coef_ptr : '0;
    data_addr  = v1 ? (ptr - k) : '0;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    state_dbg  = state;
    calc_stage = 3'b000;
    unique case (state)
      S_IDLE:  calc_stage = 3'b000;
      S_SHIFT: calc_stage = 3'b001;
      S_DONE:  calc_stage = 3'b100;
      default: calc_stage = 3'b010;
    endcase
  end

endmodule
